alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - multi-cycle ALU: single-cycle arithmetic/logic, iterative shifts and shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADC = 4'b0000;
  localparam logic [3:0] OP_SBC = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_NOT = 4'b1101;
  localparam logic [3:0] OP_SHL = 4'b1110;
  localparam logic [3:0] OP_SHR = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0]   sh_val;
  logic               sh_left;
  logic [SW-1:0]      sh_cnt;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [SW-1:0]      mul_cnt;

  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     cin;
  logic [WIDTH:0]     usum;
  logic [WIDTH:0]     udiff;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic               sc_wr_res;
  logic               sc_wr_flags;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out;
  logic [2*WIDTH-1:0] mul_sum;

  assign in_ready = (state == IDLE) && alu_en;
  assign busy     = (state != IDLE);
  assign shamt    = B[SW-1:0];

  // Carry flag feeds ADC as carry-in and SBC as borrow-in.
  assign cin   = {{WIDTH{1'b0}}, ((opcode == OP_ADC) || (opcode == OP_SBC)) && carry_flag};
  assign usum  = {1'b0, A} + {1'b0, B} + cin;
  assign udiff = {1'b0, A} - {1'b0, B} - cin;

  always_comb begin
    sc_res      = result;
    sc_c        = 1'b0;
    sc_v        = 1'b0;
    sc_wr_res   = 1'b0;
    sc_wr_flags = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        sc_res      = usum[WIDTH-1:0];
        sc_c        = usum[WIDTH];
        sc_v        = (A[WIDTH-1] == B[WIDTH-1]) && (usum[WIDTH-1] != A[WIDTH-1]);
        sc_wr_res   = 1'b1;
        sc_wr_flags = 1'b1;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        sc_res      = udiff[WIDTH-1:0];
        sc_c        = udiff[WIDTH];
        sc_v        = (A[WIDTH-1] != B[WIDTH-1]) && (udiff[WIDTH-1] != A[WIDTH-1]);
        sc_wr_res   = (opcode != OP_CMP);
        sc_wr_flags = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (opcode)
          OP_AND:  sc_res = A & B;
          OP_OR:   sc_res = A | B;
          OP_XOR:  sc_res = A ^ B;
          default: sc_res = ~A;
        endcase
        sc_wr_res   = 1'b1;
        sc_wr_flags = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        // Only reaches the register when the shift amount is zero.
        sc_res      = A;
        sc_wr_res   = 1'b1;
        sc_wr_flags = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign sh_next = sh_left ? {sh_val[WIDTH-2:0], 1'b0} : {1'b0, sh_val[WIDTH-1:1]};
  assign sh_out  = sh_left ? sh_val[WIDTH-1] : sh_val[0];
  assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : {2*WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      result        <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      out_valid     <= 1'b0;
      sh_val        <= '0;
      sh_left       <= 1'b0;
      sh_cnt        <= '0;
      mul_acc       <= '0;
      mul_mcand     <= '0;
      mul_mplier    <= '0;
      mul_cnt       <= '0;
    end else if (alu_en) begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (((opcode == OP_SHL) || (opcode == OP_SHR)) && (shamt != '0)) begin
              state   <= SHIFT;
              sh_val  <= A;
              sh_left <= (opcode == OP_SHL);
              sh_cnt  <= shamt;
            end else if (opcode == OP_MUL) begin
              state      <= MUL;
              mul_acc    <= '0;
              mul_mcand  <= {{WIDTH{1'b0}}, A};
              mul_mplier <= B;
              mul_cnt    <= '0;
            end else begin
              out_valid <= 1'b1;
              if (sc_wr_res) result <= sc_res;
              if (sc_wr_flags) begin
                zero_flag     <= (sc_res == '0);
                negative_flag <= sc_res[WIDTH-1];
                carry_flag    <= sc_c;
                overflow_flag <= sc_v;
              end
            end
          end
        end
        SHIFT: begin
          sh_val <= sh_next;
          sh_cnt <= sh_cnt - SW'(1);
          if (sh_cnt == SW'(1)) begin
            state         <= IDLE;
            out_valid     <= 1'b1;
            result        <= sh_next;
            zero_flag     <= (sh_next == '0);
            negative_flag <= sh_next[WIDTH-1];
            carry_flag    <= sh_out;
            overflow_flag <= 1'b0;
          end
        end
        MUL: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
          mul_cnt    <= mul_cnt + SW'(1);
          if (mul_cnt == SW'(WIDTH - 1)) begin
            state         <= IDLE;
            out_valid     <= 1'b1;
            result        <= mul_sum[WIDTH-1:0];
            zero_flag     <= (mul_sum[WIDTH-1:0] == '0);
            negative_flag <= mul_sum[WIDTH-1];
            carry_flag    <= (mul_sum[2*WIDTH-1:WIDTH] != '0);
            overflow_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH=8
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_en;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic [7:0] result;
  logic       zero_flag;
  logic       negative_flag;
  logic       carry_flag;
  logic       overflow_flag;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // {out_valid, result, Z, N, C, V}
  logic [12:0] obs;
  assign obs = {out_valid, result, zero_flag, negative_flag, carry_flag, overflow_flag};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .alu_en(alu_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode(opcode),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .result(result),
    .zero_flag(zero_flag),
    .negative_flag(negative_flag),
    .carry_flag(carry_flag),
    .overflow_flag(overflow_flag),
    .busy(busy)
  );

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    alu_en = 1'b1;
    issue(4'b1000, 8'h55, 8'h11);
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 13'h0 || busy !== 1'b0)
      $display("FAIL reset_outputs: got obs=%h busy=%b exp obs=0000 busy=0", obs, busy);
    if (obs !== 13'h0 || busy !== 1'b0) errors++;
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops [3] = '{4'b1000, 4'b1000, 4'b0000};
    logic [7:0]  as  [3] = '{8'h7F, 8'hFF, 8'h00};
    logic [7:0]  bs  [3] = '{8'h01, 8'h01, 8'h00};
    logic [12:0] ex  [3] = '{{1'b1, 8'h80, 4'b0101},
                             {1'b1, 8'h00, 4'b1010},
                             {1'b1, 8'h01, 4'b0000}};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got obs=%h rdy=%b exp obs=%h rdy=1", i, obs, in_ready, ex[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, 8'h01, 4'b0000}) begin
      errors++;
      $display("FAIL back_to_back_hold: got %h exp %h", obs, {1'b0, 8'h01, 4'b0000});
    end
  endtask

  task automatic test_sub_cmp;
    logic [3:0]  ops [4] = '{4'b1001, 4'b0011, 4'b0100, 4'b1010};
    logic [7:0]  as  [4] = '{8'h80, 8'h03, 8'hAA, 8'hF0};
    logic [7:0]  bs  [4] = '{8'h01, 8'h05, 8'h55, 8'h3C};
    logic [12:0] ex  [4] = '{{1'b1, 8'h7F, 4'b0001},
                             {1'b1, 8'h7F, 4'b0110},
                             {1'b1, 8'h7F, 4'b0110},
                             {1'b1, 8'h30, 4'b0000}};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL sub_cmp[%0d]: got %h exp %h", i, obs, ex[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_logic;
    logic [3:0]  ops [5] = '{4'b1011, 4'b1100, 4'b1101, 4'b1000, 4'b0001};
    logic [7:0]  as  [5] = '{8'hF0, 8'h5A, 8'h0F, 8'hFF, 8'h10};
    logic [7:0]  bs  [5] = '{8'h0F, 8'h5A, 8'h77, 8'h01, 8'h05};
    logic [12:0] ex  [5] = '{{1'b1, 8'hFF, 4'b0100},
                             {1'b1, 8'h00, 4'b1000},
                             {1'b1, 8'hF0, 4'b0100},
                             {1'b1, 8'h00, 4'b1010},
                             {1'b1, 8'h0A, 4'b0000}};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL logic[%0d]: got %h exp %h", i, obs, ex[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_shift;
    logic [3:0]  ops [3] = '{4'b1110, 4'b1111, 4'b1110};
    logic [7:0]  as  [3] = '{8'h03, 8'h81, 8'h85};
    logic [7:0]  bs  [3] = '{8'h03, 8'h09, 8'h08};
    int          ks  [3] = '{3, 1, 0};
    logic [12:0] ex  [3] = '{{1'b1, 8'h18, 4'b0000},
                             {1'b1, 8'h40, 4'b0010},
                             {1'b1, 8'h85, 4'b0100}};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < ks[i]; c++) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL shift_busy[%0d.%0d]: got busy=%b rdy=%b ov=%b exp 1 0 0", i, c, busy, in_ready, out_valid);
        end
        @(negedge clk);
      end
      checks++;
      if (obs !== ex[i] || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL shift_done[%0d]: got obs=%h busy=%b exp obs=%h busy=0", i, obs, busy, ex[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [7:0]  as [2] = '{8'h0C, 8'h10};
    logic [7:0]  bs [2] = '{8'h05, 8'h10};
    logic [12:0] ex [2] = '{{1'b1, 8'h3C, 4'b0000},
                            {1'b1, 8'h00, 4'b1010}};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      issue(4'b0010, as[i], bs[i]);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL mul_busy[%0d.%0d]: got busy=%b rdy=%b ov=%b exp 1 0 0", i, c, busy, in_ready, out_valid);
        end
        @(negedge clk);
      end
      checks++;
      if (obs !== ex[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_done[%0d]: got obs=%h busy=%b exp obs=%h busy=0", i, obs, busy, ex[i]);
      end
    end
  endtask

  task automatic test_enable_stall;
    int n;
    @(negedge clk);
    issue(4'b0010, 8'h0D, 8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    alu_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || result !== 8'h00) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ov=%b rdy=%b busy=%b res=%h exp 0 0 1 00", c, out_valid, in_ready, busy, result);
      end
    end
    alu_en = 1'b1;
    n = 6;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 12 || obs !== {1'b1, 8'h8F, 4'b0100}) begin
      errors++;
      $display("FAIL stall_done: got cycle=%0d obs=%h exp cycle=12 obs=%h", n, obs, {1'b1, 8'h8F, 4'b0100});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_pulse_width: got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic seen;
    @(negedge clk);
    issue(4'b1110, 8'h01, 8'h07);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== 13'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear: got obs=%h busy=%b rdy=%b exp 0000 0 1", obs, busy, in_ready);
    end
    issue(4'b1000, 8'h22, 8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h33, 4'b0000}) begin
      errors++;
      $display("FAIL midreset_add: got %h exp %h", obs, {1'b1, 8'h33, 4'b0000});
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_pulse: got stray=%b exp 0", seen);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alu_en = 1'b1;
    in_valid = 1'b0;
    opcode = 4'b0000;
    A = 8'h00;
    B = 8'h00;
    test_reset;
    test_back_to_back;
    test_sub_cmp;
    test_logic;
    test_shift;
    test_mul;
    test_enable_stall;
    test_reset_mid_shift;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
